// File: rtl/param_seq_alu.sv
// Handshaked ALU: single-cycle ops at full or half width, plus multi-cycle
// shifts/rotates (one bit per cycle) and an unsigned shift-add multiply.
module param_seq_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   ShAmt,
   input  logic [5:0]       FunSel,
   input  logic             WF,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] ALUOut,
   output logic [3:0]       FlagsOut
);

   localparam int unsigned W  = WIDTH;
   localparam int unsigned H  = WIDTH / 2;
   localparam int unsigned CW = SHW + 1;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state, state_nxt;
   logic [2*W-1:0]   acc, src, step_acc;
   logic [W-1:0]     b_q, mcand, mres;
   logic [W:0]       mul_sum;
   logic [2:0]       op_q, op;
   logic             wf_q, step_c, mc;
   logic [3:0]       mflags;
   logic [CW-1:0]    cnt, cnt_init;
   logic             accept, multi, rsv, zero_sh, run;

   // single-cycle datapath signals
   logic [W-1:0]     mask, aa, bb, nb, op2, sc_res;
   logic [W:0]       sum;
   logic [SHW-1:0]   msb;
   logic             full, cin, sc_c, sc_v;
   logic [3:0]       sc_flags;

   // Operation decode
   always_comb begin
      accept   = InValid & InReady;
      multi    = FunSel[5] && (FunSel[4:0] <= 5'd5);
      rsv      = FunSel[5] && !multi;
      zero_sh  = multi && (FunSel[2:0] != 3'd5) && (ShAmt == '0);
      run      = multi && !zero_sh;
      cnt_init = (FunSel[2:0] == 3'd5) ? CW'(W) : CW'(ShAmt);
   end

   // One shift/rotate/multiply step; in IDLE it runs on the incoming operands
   always_comb begin
      src      = (state == IDLE) ? {W'(0), A} : acc;
      op       = (state == IDLE) ? FunSel[2:0] : op_q;
      mcand    = (state == IDLE) ? B : b_q;
      step_acc = src;
      step_c   = 1'b0;
      mul_sum  = {1'b0, src[2*W-1:W]} + (src[0] ? {1'b0, mcand} : '0);
      case (op)
         3'd0: begin step_acc[W-1:0] = src[W-1:0] << 1; step_c = src[W-1]; end
         3'd1: begin step_acc[W-1:0] = src[W-1:0] >> 1; step_c = src[0]; end
         3'd2: begin step_acc[W-1:0] = {src[W-1], src[W-1:1]}; step_c = src[0]; end
         3'd3: begin step_acc[W-1:0] = {src[W-2:0], src[W-1]}; step_c = src[W-1]; end
         3'd4: begin step_acc[W-1:0] = {src[0], src[W-1:1]}; step_c = src[0]; end
         3'd5: step_acc = {mul_sum, src[W-1:1]};
         default: ;
      endcase
      mres   = step_acc[W-1:0];
      mc     = (op == 3'd5) ? |step_acc[2*W-1:W] : step_c;
      mflags = {mres == '0, mc, mres[W-1], 1'b0};
   end

   // Single-cycle operation set; half mode masks operands to the low half
   always_comb begin
      full   = FunSel[4];
      cin    = FlagsOut[2];
      mask   = full ? '1 : {{H{1'b0}}, {H{1'b1}}};
      aa     = A & mask;
      bb     = B & mask;
      nb     = ~B & mask;
      msb    = full ? SHW'(W-1) : SHW'(H-1);
      op2    = bb;
      sum    = '0;
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      case (FunSel[3:0])
         4'h0: sc_res = aa;
         4'h1: sc_res = bb;
         4'h2: sc_res = ~A & mask;
         4'h3: sc_res = nb;
         4'h4: sum = {1'b0, aa} + {1'b0, bb};
         4'h5: sum = {1'b0, aa} + {1'b0, bb} + (W+1)'(cin);
         4'h6: begin sum = {1'b0, aa} + {1'b0, nb} + (W+1)'(1); op2 = nb; end
         4'h7: sc_res = aa & bb;
         4'h8: sc_res = aa | bb;
         4'h9: sc_res = aa ^ bb;
         4'hA: sc_res = ~(aa & bb) & mask;
         4'hB: begin sc_res = (aa << 1) & mask; sc_c = aa[msb]; end
         4'hC: begin sc_res = aa >> 1; sc_c = aa[0]; end
         4'hD: begin sc_res = (aa >> 1) | (W'(aa[msb]) << msb); sc_c = aa[0]; end
         4'hE: begin sc_res = ((aa << 1) | W'(cin)) & mask; sc_c = aa[msb]; end
         4'hF: begin sc_res = (aa >> 1) | (W'(cin) << msb); sc_c = aa[0]; end
      endcase
      if (FunSel[3:0] inside {4'h4, 4'h5, 4'h6}) begin
         sc_res = sum[W-1:0] & mask;
         sc_c   = full ? sum[W] : sum[H];
         sc_v   = (aa[msb] == op2[msb]) && (sc_res[msb] != aa[msb]);
      end
      sc_flags = {sc_res == '0, sc_c, sc_res[msb], sc_v};
   end

   // State register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (run && cnt_init != CW'(1)) ? EXEC : DONE;
         EXEC: if (cnt == CW'(1)) state_nxt = DONE;
         DONE: if (OutReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      InReady  = (state == IDLE);
      OutValid = (state == DONE);
   end

   // Operand capture, iteration and result/flag registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         acc      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         wf_q     <= 1'b0;
         cnt      <= '0;
         ALUOut   <= '0;
         FlagsOut <= '0;
      end else if (state == IDLE && accept) begin
         op_q <= FunSel[2:0];
         b_q  <= B;
         wf_q <= WF;
         if (!FunSel[5]) begin
            ALUOut <= sc_res;
            if (WF) FlagsOut <= sc_flags;
         end else if (rsv) begin
            ALUOut <= '0;
         end else if (zero_sh) begin
            ALUOut <= A;
            if (WF) FlagsOut <= {A == '0, 1'b0, A[W-1], 1'b0};
         end else if (cnt_init == CW'(1)) begin
            ALUOut <= mres;
            if (WF) FlagsOut <= mflags;
         end else begin
            acc <= step_acc;
            cnt <= cnt_init - CW'(1);
         end
      end else if (state == EXEC) begin
         acc <= step_acc;
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            ALUOut <= mres;
            if (wf_q) FlagsOut <= mflags;
         end
      end
   end

endmodule

// File: tb/tb_param_seq_alu.sv
// Directed bench for param_seq_alu (WIDTH=32) checked against an arithmetic
// reference model, with literal expectations pinning the model.
module tb_param_seq_alu;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        InValid, InReady, WF, OutValid, OutReady;
   logic [31:0] A, B, ALUOut;
   logic [4:0]  ShAmt;
   logic [5:0]  FunSel;
   logic [3:0]  FlagsOut;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_res;
   logic [3:0]  exp_flags;
   logic [3:0]  mflags;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [5:0]  fun;
      logic        wf;
      logic [31:0] er;
      logic [3:0]  ef;
   } vec_t;

   param_seq_alu #(.WIDTH(32)) dut (
      .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .A(A), .B(B), .ShAmt(ShAmt), .FunSel(FunSel), .WF(WF),
      .OutValid(OutValid), .OutReady(OutReady), .ALUOut(ALUOut), .FlagsOut(FlagsOut)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: results, flags and latency from plain arithmetic
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                 input logic [5:0] fun, input logic wf, input logic [3:0] fin,
                                 output logic [31:0] res, output logic [3:0] fout, output int lat);
      int          n;
      logic [63:0] m, x, y, r, p;
      longint      sx, sy, s, lim;
      logic        c, v, cin, rsv;
      c = 1'b0; v = 1'b0; rsv = 1'b0; lat = 1; r = '0; cin = fin[2];
      if (!fun[5]) begin
         n   = fun[4] ? 32 : 16;
         m   = (64'd1 << n) - 64'd1;
         x   = {32'd0, a} & m;
         y   = {32'd0, b} & m;
         sx  = x[n-1] ? longint'(x) - (longint'(1) << n) : longint'(x);
         sy  = y[n-1] ? longint'(y) - (longint'(1) << n) : longint'(y);
         lim = longint'(1) << (n-1);
         case (fun[3:0])
            4'h0: r = x;
            4'h1: r = y;
            4'h2: r = ~x & m;
            4'h3: r = ~y & m;
            4'h4: begin p = x + y; r = p & m; c = p[n]; s = sx + sy; v = (s >= lim) || (s < -lim); end
            4'h5: begin p = x + y + 64'(cin); r = p & m; c = p[n];
                        s = sx + sy + longint'(cin); v = (s >= lim) || (s < -lim); end
            4'h6: begin r = (x - y) & m; c = (x >= y); s = sx - sy; v = (s >= lim) || (s < -lim); end
            4'h7: r = x & y;
            4'h8: r = x | y;
            4'h9: r = x ^ y;
            4'hA: r = ~(x & y) & m;
            4'hB: begin r = (x << 1) & m; c = x[n-1]; end
            4'hC: begin r = x >> 1; c = x[0]; end
            4'hD: begin r = (x >> 1) | (x & (64'd1 << (n-1))); c = x[0]; end
            4'hE: begin r = ((x << 1) | 64'(cin)) & m; c = x[n-1]; end
            4'hF: begin r = (x >> 1) | (64'(cin) << (n-1)); c = x[0]; end
         endcase
      end else begin
         n = 32;
         m = 64'hFFFF_FFFF;
         x = {32'd0, a};
         case (fun[4:0])
            5'd0: begin r = (x << sh) & m; c = (sh != 0) ? x[32-int'(sh)] : 1'b0; end
            5'd1: begin r = x >> sh; c = (sh != 0) ? x[int'(sh)-1] : 1'b0; end
            5'd2: begin r = {32'd0, 32'($signed(a) >>> sh)}; c = (sh != 0) ? x[int'(sh)-1] : 1'b0; end
            5'd3: begin r = ((x << sh) | (x >> (32-int'(sh)))) & m; c = (sh != 0) ? r[0] : 1'b0; end
            5'd4: begin r = ((x >> sh) | (x << (32-int'(sh)))) & m; c = (sh != 0) ? r[31] : 1'b0; end
            5'd5: begin p = x * {32'd0, b}; r = {32'd0, p[31:0]}; c = |p[63:32]; lat = 32; end
            default: rsv = 1'b1;
         endcase
         if (fun[4:0] <= 5'd4 && sh != 0) lat = int'(sh);
      end
      res  = r[31:0];
      fout = (wf && !rsv) ? {res == 32'd0, c, r[n-1], v} : fin;
   endfunction

   // Output checker: whenever a result is presented it must match the model
   always @(negedge Clock) begin
      if (Reset === 1'b1 && OutValid === 1'b1) begin
         check("aluout", ALUOut, exp_res);
         check("flags", FlagsOut, exp_flags);
         check("inready_busy", InReady, 64'd0);
      end
   end

   task automatic run_op(input vec_t v, input int hold);
      logic [31:0] r;
      logic [3:0]  f;
      int          lat, el, guard;
      model(v.a, v.b, v.sh, v.fun, v.wf, mflags, r, f, el);
      check("pin_res", r, v.er);
      check("pin_flags", f, v.ef);
      guard = 0;
      while (InReady !== 1'b1 && guard < 100) begin @(negedge Clock); guard++; end
      @(negedge Clock);
      exp_res = r; exp_flags = f;
      A = v.a; B = v.b; ShAmt = v.sh; FunSel = v.fun; WF = v.wf; InValid = 1'b1;
      @(posedge Clock); #1;
      InValid = 1'b0;
      A = $urandom; B = $urandom; ShAmt = 5'($urandom); FunSel = 6'($urandom); WF = 1'($urandom);
      lat = 1;
      while (OutValid !== 1'b1 && lat < 100) begin @(posedge Clock); #1; lat++; end
      check("latency", lat, el);
      mflags = f;
      repeat (hold) @(negedge Clock);
      @(negedge Clock); OutReady = 1'b1;
      @(posedge Clock); #1 OutReady = 1'b0;
      check("release_valid", OutValid, 64'd0);
      check("release_ready", InReady, 64'd1);
   endtask

   vec_t vecs [26] = '{
      '{32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  6'h14, 1'b1, 32'h0000_0000, 4'b1100},
      '{32'h0001_7FFF, 32'h0000_0001, 5'd0,  6'h04, 1'b1, 32'h0000_8000, 4'b0011},
      '{32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  6'h14, 1'b1, 32'h0000_0000, 4'b1100},
      '{32'h0000_0002, 32'h0000_0003, 5'd0,  6'h05, 1'b1, 32'h0000_0006, 4'b0000},
      '{32'h0000_0005, 32'h0000_0007, 5'd0,  6'h06, 1'b1, 32'h0000_FFFE, 4'b0010},
      '{32'h0000_0007, 32'h0000_0005, 5'd0,  6'h16, 1'b1, 32'h0000_0002, 4'b0100},
      '{32'hFFFF_0F0F, 32'h1234_FF00, 5'd0,  6'h07, 1'b1, 32'h0000_0F00, 4'b0000},
      '{32'hFFFF_0000, 32'hFFFF_FFFF, 5'd0,  6'h19, 1'b1, 32'h0000_FFFF, 4'b0000},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  6'h1A, 1'b1, 32'h0000_0000, 4'b1000},
      '{32'h0000_FFFF, 32'h0000_0000, 5'd0,  6'h02, 1'b1, 32'h0000_0000, 4'b1000},
      '{32'h8000_0001, 32'h0000_0000, 5'd0,  6'h1B, 1'b1, 32'h0000_0002, 4'b0100},
      '{32'h0000_8001, 32'h0000_0000, 5'd0,  6'h0D, 1'b1, 32'h0000_C000, 4'b0110},
      '{32'h4000_0000, 32'h0000_0000, 5'd0,  6'h1E, 1'b1, 32'h8000_0001, 4'b0010},
      '{32'h0000_0003, 32'h0000_0000, 5'd0,  6'h1F, 1'b1, 32'h0000_0001, 4'b0100},
      '{32'h8000_0001, 32'h0000_0000, 5'd4,  6'h21, 1'b1, 32'h0800_0000, 4'b0000},
      '{32'h8000_0001, 32'h0000_0000, 5'd1,  6'h21, 1'b1, 32'h4000_0000, 4'b0100},
      '{32'h8000_0001, 32'h0000_0000, 5'd0,  6'h21, 1'b1, 32'h8000_0001, 4'b0010},
      '{32'h0000_0003, 32'h0000_0000, 5'd31, 6'h20, 1'b1, 32'h8000_0000, 4'b0110},
      '{32'h8000_0000, 32'h0000_0000, 5'd4,  6'h22, 1'b1, 32'hF800_0000, 4'b0010},
      '{32'h1234_5678, 32'h0000_0000, 5'd8,  6'h23, 1'b1, 32'h3456_7812, 4'b0000},
      '{32'h1234_5678, 32'h0000_0000, 5'd4,  6'h24, 1'b1, 32'h8123_4567, 4'b0110},
      '{32'h0001_0000, 32'h0001_0001, 5'd0,  6'h25, 1'b1, 32'h0001_0000, 4'b0100},
      '{32'h0000_0003, 32'h0000_0005, 5'd0,  6'h25, 1'b0, 32'h0000_000F, 4'b0100},
      '{32'h0000_0001, 32'h0000_0001, 5'd0,  6'h26, 1'b1, 32'h0000_0000, 4'b0100},
      '{32'h0000_0001, 32'h0000_0001, 5'd3,  6'h3F, 1'b1, 32'h0000_0000, 4'b0100},
      '{32'h0000_FFFF, 32'hFFFF_0001, 5'd0,  6'h04, 1'b1, 32'h0000_0000, 4'b1100}
   };

   vec_t hold_vec  = '{32'h0F0F_0000, 32'h0000_00F0, 5'd0, 6'h18, 1'b1, 32'h0F0F_00F0, 4'b0000};
   vec_t after_rst = '{32'h0000_0001, 32'h0000_0002, 5'd0, 6'h14, 1'b1, 32'h0000_0003, 4'b0000};

   initial begin
      Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0; WF = 1'b0;
      A = '0; B = '0; ShAmt = '0; FunSel = '0;
      exp_res = '0; exp_flags = '0; mflags = '0;
      repeat (2) @(posedge Clock);
      #1;
      check("rst_inready", InReady, 64'd1);
      check("rst_outvalid", OutValid, 64'd0);
      check("rst_aluout", ALUOut, 64'd0);
      check("rst_flags", FlagsOut, 64'd0);
      @(negedge Clock) Reset = 1'b1;

      foreach (vecs[i]) run_op(vecs[i], 0);
      run_op(hold_vec, 5);

      // Reset in the middle of a multiply abandons it
      @(negedge Clock);
      A = 32'h1234_5678; B = 32'h0000_0100; FunSel = 6'h25; WF = 1'b1; InValid = 1'b1;
      @(posedge Clock); #1 InValid = 1'b0;
      repeat (10) @(posedge Clock);
      #1 Reset = 1'b0;
      #1;
      check("midrst_aluout", ALUOut, 64'd0);
      check("midrst_flags", FlagsOut, 64'd0);
      check("midrst_inready", InReady, 64'd1);
      check("midrst_outvalid", OutValid, 64'd0);
      mflags = '0;
      @(negedge Clock) Reset = 1'b1;
      run_op(after_rst, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
